// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between a requester (master) and the
// iterative multiply/divide unit (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [2:0]       MDControl;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] MDResult;
  logic             DivZero;

  modport master (
    output Start, SrcA, SrcB, MDControl,
    input  Busy, Done, MDResult, DivZero
  );

  modport slave (
    input  Start, SrcA, SrcB, MDControl,
    output Busy, Done, MDResult, DivZero
  );
endinterface

// File: rtl/muldiv.sv
// muldiv: radix-2 iterative multiplier/divider with fixed WIDTH+1 cycle latency.
// Signed MULH/MULHSU/DIV/REM are built only when MULDIV_SIGNED_EN is defined.
module muldiv #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dz_q, dz_d;
  logic             divzero_q, divzero_d;

  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept = (state_q == S_IDLE) && bus.Start;

  // hi/lo hold {product_hi, multiplier} for multiplies and
  // {partial_remainder, dividend/quotient} for divides.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, b_q};

`ifdef MULDIV_SIGNED_EN
  logic a_signed, b_signed, a_neg, b_neg;
  logic neg_q, neg_rem_q;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (bus.MDControl[2]) begin
      a_signed = ~bus.MDControl[0];
      b_signed = ~bus.MDControl[0];
    end else begin
      a_signed = (bus.MDControl == OP_MULH) || (bus.MDControl == OP_MULHSU);
      b_signed = (bus.MDControl == OP_MULH);
    end
  end

  assign a_neg = a_signed && bus.SrcA[WIDTH-1];
  assign b_neg = b_signed && bus.SrcB[WIDTH-1];
  assign a_mag = a_neg ? -bus.SrcA : bus.SrcA;
  assign b_mag = b_neg ? -bus.SrcB : bus.SrcB;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end
  end

  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quot_fix = neg_q ? -lo_q : lo_q;
  assign rem_fix  = neg_rem_q ? -hi_q : hi_q;
`else
  assign a_mag    = bus.SrcA;
  assign b_mag    = bus.SrcB;
  assign prod_fix = {hi_q, lo_q};
  assign quot_fix = lo_q;
  assign rem_fix  = hi_q;
`endif

  logic [WIDTH-1:0] result_fin;

  always_comb begin
    result_fin = rem_fix;
    case (op_q)
      OP_MUL:                       result_fin = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_fin = prod_fix[2*WIDTH-1:WIDTH];
      // Divide-by-zero quotient is forced so sign fix-up cannot disturb it.
      OP_DIV, OP_DIVU:              result_fin = dz_q ? {WIDTH{1'b1}} : quot_fix;
      default:                      result_fin = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    result_d  = result_q;
    divzero_d = divzero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = bus.MDControl;
          b_d     = b_mag;
          hi_d    = '0;
          lo_d    = a_mag;
          dz_d    = bus.MDControl[2] && (bus.SrcB == '0);
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d   = S_DONE;
          result_d  = result_fin;
          divzero_d = dz_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (op_q[2]) begin
            if (!div_trial[WIDTH]) begin
              hi_d = div_trial[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_d = div_shift[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
      result_q  <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
      result_q  <= result_d;
      divzero_q <= divzero_d;
    end
  end

  assign bus.Busy     = (state_q != S_IDLE);
  assign bus.Done     = (state_q == S_DONE);
  assign bus.MDResult = result_q;
  assign bus.DivZero  = divzero_q;
endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port SrcA, input, WIDTH bits: multiplicand or dividend.
REQ-006 SHALL have port SrcB, input, WIDTH bits: multiplier or divisor.
REQ-007 SHALL have port MDControl, input, 3 bits selecting the operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port Busy, output, 1 bit: an operation is in progress.
REQ-009 SHALL have port Done, output, 1 bit: one-cycle pulse marking MDResult valid.
REQ-010 SHALL have port MDResult, output, WIDTH bits: result of the operation.
REQ-011 SHALL have port DivZero, output, 1 bit: the last completed divide or remainder had SrcB equal to 0.

Function
REQ-012 SHALL implement three states. IDLE goes to RUN when Start=1. RUN goes to DONE after WIDTH iterations. DONE goes to IDLE after one cycle.
REQ-013 SHALL, on the edge where Start is accepted, latch SrcA, SrcB and MDControl; later changes to these inputs have no effect on the operation.
REQ-014 SHALL perform one radix-2 iteration per RUN cycle: shift-add for multiplies, restoring shift-subtract for divides and remainders.
REQ-015 SHALL have fixed latency: Done=1 for exactly one cycle, WIDTH+1 cycles after the accepting edge (cycle 33 for WIDTH=32). This holds for every opcode and operand value.
REQ-016 SHALL hold Busy=1 from the cycle after the accepting edge until Done, inclusive.
REQ-017 SHALL ignore Start while Busy=1; no queuing and no restart.
REQ-018 SHALL hold MDResult and DivZero stable from Done until the next accepted Start completes.
REQ-019 SHALL return the low WIDTH bits of the 2*WIDTH-bit product for MUL.
REQ-020 SHALL return the high WIDTH bits of the product for MULH, MULHSU and MULHU, using the signedness given in REQ-026 and REQ-027.
REQ-021 SHALL, on divide by zero, set the quotient to all ones, set the remainder to SrcA, and set DivZero=1.
REQ-022 SHALL set DivZero=0 on completion of any operation that is not a divide by zero.
REQ-023 SHALL, for signed overflow (SrcA = most negative value, SrcB = all ones, with the macro defined), return quotient = SrcA and remainder = 0, with DivZero=0.

Reset
REQ-024 SHALL, while reset=1 (including mid-RUN), force the state to IDLE and drive Busy=0, Done=0, MDResult=0 and DivZero=0, asynchronously and without waiting for clk.
REQ-025 SHALL, after reset deasserts, accept Start on the first rising edge.

Configuration
REQ-026 SHALL, when macro MULDIV_SIGNED_EN is defined, implement signed semantics:
- MULH: signed x signed.
- MULHSU: signed x unsigned.
- DIV and REM: signed, quotient truncated toward zero, remainder taking the sign of the dividend.
- Implementation: operand sign-correction before iterating, result negation after.
REQ-027 SHALL, when MULDIV_SIGNED_EN is not defined:
- treat MULH and MULHSU as MULHU, DIV as DIVU, and REM as REMU;
- omit all sign-correction logic;
- keep the latency unchanged.

Verification
REQ-028 SHALL cover: MUL, SrcA=7, SrcB=6 -> Done at cycle 33, MDResult=42, DivZero=0.
REQ-029 SHALL cover: MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> MDResult=0xFFFFFFFE; then MUL on the same operands -> 0x00000001.
REQ-030 SHALL cover: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x1234/0 -> 0xFFFFFFFF with DivZero=1; REMU 0x1234/0 -> 0x1234.
REQ-031 SHALL cover, with MULDIV_SIGNED_EN defined:
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD;
- REM of the same operands -> 0xFFFFFFFF;
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
- REM of the same operands -> 0.
REQ-032 SHALL cover, without MULDIV_SIGNED_EN: DIV 0xFFFFFFF9/2 -> 0x7FFFFFFC.
REQ-033 SHALL cover: Start pulsed again at cycle 5 of RUN with different operands -> ignored, original result delivered at cycle 33.
REQ-034 SHALL cover: reset asserted at RUN cycle 10 -> Busy, Done, MDResult and DivZero all 0 immediately; a new Start after reset completes normally.
